// File: rtl/axi_slave_pkg.sv
// Shared constants for the AXI4 SRAM slave: channel widths, FSM state encodings,
// response codes and burst type.
package axi_slave_pkg;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;
  localparam int STRB_W = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_FETCH = 3'd1;
  localparam logic [2:0] ST_RD_DATA  = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_RESP  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // WLAST must be high exactly on the beat where the counter reaches LEN.
  function automatic logic wlast_mismatch(input logic wlast, input logic last_beat);
    return wlast != last_beat;
  endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 slave serving one INCR burst at a time from a single-port synchronous SRAM.
// Reads cost two cycles per beat (fetch + data); writes stream one beat per cycle.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [SIZE_W-1:0]   AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [STRB_W-1:0]   WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [SIZE_W-1:0]   ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                CS,
  output logic                OE,
  output logic [STRB_W-1:0]   WEB,
  output logic [SRAM_AW-1:0]  A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  logic [2:0]         state_r;
  logic [SRAM_AW-1:0] addr_r;
  logic [LEN_W-1:0]   beat_r;
  logic [LEN_W-1:0]   len_r;
  logic [ID_W-1:0]    id_r;
  logic               slverr_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               fresh_r;

  logic ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, last_beat_s;

  // Burst type, size and out-of-range address bits carry no meaning here.
  logic unused_s;
  assign unused_s = ^{AWSIZE, ARSIZE, AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0],
                      ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0],
                      (AWBURST == BURST_INCR), (ARBURST == BURST_INCR)};

  // READYs are held low while rst is asserted so no handshake can start during reset.
  assign ARREADY = (state_r == ST_IDLE) & ~rst;
  assign AWREADY = (state_r == ST_IDLE) & ~ARVALID & ~rst;
  assign WREADY  = (state_r == ST_WR_DATA) & ~rst;

  assign ar_hs_s     = ARVALID & ARREADY;
  assign aw_hs_s     = AWVALID & AWREADY;
  assign w_hs_s      = WVALID & WREADY;
  assign r_hs_s      = RVALID & RREADY;
  assign last_beat_s = (beat_r == len_r);

  assign RVALID = (state_r == ST_RD_DATA);
  assign RLAST  = (state_r == ST_RD_DATA) & last_beat_s;
  assign RID    = id_r;
  assign RRESP  = RESP_OKAY;
  // DO is only valid in the first RD_DATA cycle; afterwards the captured copy holds the beat.
  assign RDATA  = fresh_r ? DO : rdata_r;

  assign BVALID = (state_r == ST_WR_RESP);
  assign BID    = id_r;
  assign BRESP  = ((state_r == ST_WR_RESP) && slverr_r) ? RESP_SLVERR : RESP_OKAY;

  assign CS  = (state_r == ST_RD_FETCH) | w_hs_s;
  assign OE  = (state_r == ST_RD_FETCH);
  assign A   = addr_r;
  assign WEB = w_hs_s ? ~WSTRB : 4'hF;
  assign DI  = w_hs_s ? WDATA : 32'h0000_0000;

  // Transaction FSM with address/beat counters and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      beat_r   <= 4'd0;
      len_r    <= 4'd0;
      id_r     <= 8'h00;
      slverr_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      fresh_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ar_hs_s) begin
            id_r    <= ARID;
            len_r   <= ARLEN;
            addr_r  <= ARADDR[SRAM_AW+1:2];
            beat_r  <= 4'd0;
            state_r <= ST_RD_FETCH;
          end else if (aw_hs_s) begin
            id_r     <= AWID;
            len_r    <= AWLEN;
            addr_r   <= AWADDR[SRAM_AW+1:2];
            beat_r   <= 4'd0;
            slverr_r <= 1'b0;
            state_r  <= ST_WR_DATA;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_FETCH: begin
          fresh_r <= 1'b1;
          state_r <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (fresh_r) begin
            rdata_r <= DO;
            fresh_r <= 1'b0;
          end
          if (r_hs_s) begin
            if (last_beat_s) begin
              state_r <= ST_IDLE;
            end else begin
              addr_r  <= addr_r + SRAM_AW'(1);
              beat_r  <= beat_r + 4'd1;
              state_r <= ST_RD_FETCH;
            end
          end
        end
        ST_WR_DATA: begin
          if (w_hs_s) begin
            addr_r <= addr_r + SRAM_AW'(1);
            beat_r <= beat_r + 4'd1;
            if (wlast_mismatch(WLAST, last_beat_s)) begin
              slverr_r <= 1'b1;
            end
            if (last_beat_s) begin
              state_r <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (BREADY) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of single-beat vectors plus hand-written
// burst, arbitration, backpressure, protocol-error and reset sequences.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, DI, DO;
  logic [3:0]  AWLEN, ARLEN, WSTRB, WEB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CS, OE;
  logic [13:0] A;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  axi_sram_slave #(.SRAM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  // Synchronous SRAM model: registered read, byte-masked write.
  always @(posedge clk) begin
    if (CS && OE) DO <= mem[A];
    if (CS) begin
      for (int b = 0; b < 4; b++) begin
        if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake never came (timeout)", name);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [127:0] act, exp;
    act = {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, RDATA, RID, BID,
           RRESP, BRESP, CS, OE, WEB, A, DI};
    exp = {6'b000000, 32'h0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 4'hF, 14'h0000, 32'h0};
    chk(name, act, exp);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                             input logic [31:0] d0, input logic [3:0] strb,
                             input logic [3:0] exp_web, input logic [13:0] exp_a0,
                             input int last_at, output logic [1:0] bresp, output logic [7:0] bid);
    int n;
    logic [13:0] ea;
    bresp = 2'b11;
    bid   = 8'hFF;
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id; AWSIZE = 3'd2; AWBURST = 2'b01;
    #1; n = 0;
    while (!AWREADY && n < 50) begin @(negedge clk); #1; n++; end
    if (!AWREADY) begin fail_timeout("aw_ready"); AWVALID = 1'b0; return; end
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = d0 + i; WSTRB = strb; WLAST = (i == last_at);
      #1;
      ea = exp_a0 + 14'(i);
      chk("w_ready", WREADY, 1'b1);
      chk("w_web", WEB, exp_web);
      chk("w_addr", A, ea);
      chk("w_di", DI, d0 + i);
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    #1;
    chk("b_valid_next_cycle", BVALID, 1'b1);
    n = 0;
    while (!BVALID && n < 50) begin @(negedge clk); #1; n++; end
    if (!BVALID) begin fail_timeout("b_valid"); BREADY = 1'b0; return; end
    bresp = BRESP;
    bid   = BID;
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                            input logic [31:0] e0, input int hold);
    int n;
    RREADY = (hold == 0);
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id; ARSIZE = 3'd2; ARBURST = 2'b01;
    #1; n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); #1; n++; end
    if (!ARREADY) begin fail_timeout("ar_ready"); ARVALID = 1'b0; return; end
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      do begin
        @(negedge clk);
        ARVALID = 1'b0;
        #1; n++;
      end while (!RVALID && n < 20);
      if (!RVALID) begin fail_timeout("r_valid"); return; end
      chk("r_latency", n, 2);
      chk("r_data", RDATA, e0 + i);
      chk("r_id", RID, id);
      chk("r_last", RLAST, (i == int'(len)));
      chk("r_resp", RRESP, 2'b00);
      if (i == 0 && hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk); #1;
          chk("r_hold_valid", RVALID, 1'b1);
          chk("r_hold_data", RDATA, e0);
        end
        RREADY = 1'b1;
      end
    end
    @(negedge clk); #1;
    chk("r_idle_after_last", RVALID, 1'b0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  exp_web;
    logic [13:0] exp_a;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [1:0] br;
    logic [7:0] bi;
    // Global watchdog.
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    // wr: data/strb/exp_web/exp_a apply; rd: data is the expected RDATA.
    vecs[0] = '{1'b1, 32'h0000_0010, 8'h21, 32'hDEAD_BEEF, 4'hF, 4'h0, 14'h0004};
    vecs[1] = '{1'b0, 32'h0000_0010, 8'h12, 32'hDEAD_BEEF, 4'hF, 4'hF, 14'h0004};
    vecs[2] = '{1'b1, 32'h0000_0200, 8'h31, 32'h1122_3344, 4'hF, 4'h0, 14'h0080};
    vecs[3] = '{1'b1, 32'h0000_0200, 8'h32, 32'hAABB_CCDD, 4'b0101, 4'b1010, 14'h0080};
    vecs[4] = '{1'b0, 32'h0000_0200, 8'h33, 32'h11BB_33DD, 4'hF, 4'hF, 14'h0080};
    vecs[5] = '{1'b1, 32'h0003_FFFC, 8'h41, 32'hCAFE_F00D, 4'hF, 4'h0, 14'h3FFF};
    vecs[6] = '{1'b0, 32'h0000_FFFC, 8'h42, 32'hCAFE_F00D, 4'hF, 4'hF, 14'h3FFF};

    rst = 1'b1;
    AWID = 8'h00; AWADDR = 32'h0; AWLEN = 4'd0; AWSIZE = 3'd0; AWBURST = 2'b00; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 8'h00; ARADDR = 32'h0; ARLEN = 4'd0; ARSIZE = 3'd0; ARBURST = 2'b00; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wr) begin
        write_burst(vecs[v].addr, 4'd0, vecs[v].id, vecs[v].data, vecs[v].strb,
                    vecs[v].exp_web, vecs[v].exp_a, 0, br, bi);
        chk("vec_bresp", br, 2'b00);
        chk("vec_bid", bi, vecs[v].id);
      end else begin
        read_burst(vecs[v].addr, 4'd0, vecs[v].id, vecs[v].data, 0);
      end
    end

    // 4-beat burst write then read back.
    write_burst(32'h0000_0100, 4'd3, 8'h55, 32'h1, 4'hF, 4'h0, 14'h0040, 3, br, bi);
    chk("burst_bresp", br, 2'b00);
    chk("burst_bid", bi, 8'h55);
    read_burst(32'h0000_0100, 4'd3, 8'h56, 32'h1, 0);

    // Simultaneous AR and AW: read first, write accepted on return to IDLE.
    @(negedge clk);
    RREADY = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h0000_0010; ARLEN = 4'd0; ARID = 8'h33;
    AWVALID = 1'b1; AWADDR = 32'h0000_0300; AWLEN = 4'd0; AWID = 8'h44;
    #1;
    chk("sim_arready", ARREADY, 1'b1);
    chk("sim_awready_blocked", AWREADY, 1'b0);
    @(negedge clk); ARVALID = 1'b0; #1;
    chk("sim_aw_blocked_fetch", AWREADY, 1'b0);
    @(negedge clk); #1;
    chk("sim_rvalid", RVALID, 1'b1);
    chk("sim_rdata", RDATA, 32'hDEAD_BEEF);
    chk("sim_rid", RID, 8'h33);
    chk("sim_aw_blocked_data", AWREADY, 1'b0);
    @(negedge clk); #1;
    chk("sim_aw_accept_idle", AWREADY, 1'b1);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'h55AA_55AA; WSTRB = 4'hF; WLAST = 1'b1;
    #1;
    chk("sim_wready", WREADY, 1'b1);
    chk("sim_waddr", A, 14'h00C0);
    @(negedge clk);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    #1;
    chk("sim_bvalid", BVALID, 1'b1);
    chk("sim_bid", BID, 8'h44);
    chk("sim_bresp", BRESP, 2'b00);
    @(negedge clk);
    BREADY = 1'b0;
    read_burst(32'h0000_0300, 4'd0, 8'h45, 32'h55AA_55AA, 0);

    // Backpressure: RREADY low for 5 cycles on the first beat.
    read_burst(32'h0000_0100, 4'd3, 8'h66, 32'h1, 5);

    // Early WLAST on beat 2 of a 4-beat burst, then a missing WLAST.
    write_burst(32'h0000_0400, 4'd3, 8'h71, 32'h10, 4'hF, 4'h0, 14'h0100, 1, br, bi);
    chk("early_wlast_bresp", br, 2'b10);
    read_burst(32'h0000_0400, 4'd3, 8'h72, 32'h10, 0);
    write_burst(32'h0000_0500, 4'd1, 8'h73, 32'h20, 4'hF, 4'h0, 14'h0140, 99, br, bi);
    chk("missing_wlast_bresp", br, 2'b10);

    // Reset asserted while a read beat is pending.
    @(negedge clk);
    RREADY = 1'b0;
    ARVALID = 1'b1; ARADDR = 32'h0000_0100; ARLEN = 4'd3; ARID = 8'h5A;
    @(negedge clk); ARVALID = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_rvalid", RVALID, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("rst_mid_outputs");
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_idle_arready", ARREADY, 1'b1);
    chk("rst_mid_no_rvalid", RVALID, 1'b0);
    read_burst(32'h0000_0010, 4'd0, 8'h77, 32'hDEAD_BEEF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave that answers read and write bursts from the CPU-side masters (instruction and data cache refills, data write-through) and drives a single-port synchronous SRAM macro. It sits behind the AXI interconnect, one instance per memory (IM, DM). Transactions are serialised, with one transaction in flight at a time. INCR bursts of up to 16 beats serve cache-line fills.

## Interface
Widths come from the shared AXI define header: ID = `AXI_IDS_BITS` (8), ADDR = 32, DATA = 32, LEN = 4, SIZE = 3, STRB = 4.

Parameters:
- SRAM_AW, default 14: SRAM word-address width, giving 16K words (64 KB).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  **synchronous, active-high reset**.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in, AWREADY  out: write-address channel.
- WDATA/WSTRB/WLAST/WVALID  in, WREADY  out: write-data channel.
- BID  out  8, BRESP  out  2, BVALID  out  1, BREADY  in  1: write-response channel.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in, ARREADY  out: read-address channel.
- RID  out  8, RDATA  out  32, RRESP  out  2, RLAST  out  1, RVALID  out  1, RREADY  in  1: read-data channel.
- CS  out  1: SRAM chip select.
- OE  out  1: SRAM output enable.
- WEB  out  4: per-byte write enable, active-low.
- A  out  SRAM_AW: SRAM word address.
- DI  out  32: SRAM write data.
- DO  in  32: SRAM read data, valid one cycle after the read address is presented.

## Operation
- **FSM states:** IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP.
- **Address capture:** on an address handshake, latch ID, LEN, and word address = addr[SRAM_AW+1:2]. Clear the beat counter.
- **Address range:** upper address bits are ignored, so out-of-range addresses alias. Address decode belongs to the interconnect.
- **IDLE:**
  - ARREADY = 1.
  - AWREADY = ~ARVALID, so a read wins when AR and AW are valid in the same cycle; the AW waits.
  - AR handshake → RD_FETCH.
  - AW handshake → WR_DATA.
- **RD_FETCH:** CS = OE = 1, A = current address, WEB = 4'hF. Always advance to RD_DATA next cycle and capture DO into the read-data register.
- **RD_DATA:**
  - RVALID = 1, RDATA = read-data register (held stable while RREADY = 0), RID = latched ID.
  - RLAST = (beat counter == LEN).
  - On R handshake: if last → IDLE; else address+1, counter+1 → RD_FETCH.
- **WR_DATA:**
  - WREADY = 1.
  - On W handshake the same cycle: CS = 1, A = current address, DI = WDATA, WEB = ~WSTRB. This is a single-cycle write.
  - Address+1, counter+1.
  - When counter == LEN at the handshake → WR_RESP.
- **WR_RESP:** BVALID = 1, BID = latched ID. On BREADY → IDLE.
- **Responses:**
  - RRESP = OKAY (2'b00).
  - BRESP = OKAY, or SLVERR (2'b10) if WLAST was ever inconsistent with the beat count (early or missing).
  - The burst always terminates on the count.
- **Non-INCR bursts:** AWBURST/ARBURST other than INCR are served as INCR.
- **SIZE:** ignored; every beat is one 32-bit word.
- **Address counter:** wraps modulo 2^SRAM_AW.

## Timing
- **Reset values:** all READY/VALID = 0, RLAST = 0, RDATA = 0, RID = BID = 0, RRESP = BRESP = 0, CS = OE = 0, WEB = 4'hF, A = 0, DI = 0. State = IDLE.
- **Reset mid-transaction:** abort the transaction; outputs take their reset values on the cycle after rst is sampled high. No partial response is produced.
- **Read latency:** AR handshake at edge t → RVALID at t+2. Each further beat costs 2 cycles after its R handshake. A 4-beat burst with RREADY held at 1 takes 8 cycles from AR handshake to the last handshake.
- **Write throughput:** one beat per cycle. BVALID is asserted the cycle after the final W handshake.
- **Handshake rule:** VALID outputs never drop without a handshake, and payload is stable while VALID = 1 and READY = 0.
- **Independent channels:** no AR/AW is accepted outside IDLE. A WVALID arriving before the AW handshake is not accepted.

## Structure
- **Shared package axi_slave_pkg:** state enum, RESP_OKAY/RESP_SLVERR, BURST_INCR.
- **Logic:** one module. The FSM plus address/beat counters fit in about 200 lines.
- **Sub-modules:** none. The SRAM macro is instantiated by the parent.

## Test plan
- **Single read:** AR addr 0x0000_0010, LEN 0, ID 0x12, RREADY = 1, SRAM word 4 = 0xDEADBEEF → RDATA 0xDEADBEEF, RID 0x12, RLAST = 1, RRESP 0, RVALID 2 cycles after the handshake.
- **Burst write then read:** AW addr 0x100, LEN 3, WSTRB 4'hF, data 1..4, then AR of the same burst → A = 0x40..0x43 written. Read returns 1..4 with RLAST only on beat 4 and BRESP OKAY.
- **Byte strobe:** write 0xAABBCCDD with WSTRB 4'b0101 over 0x11223344 → WEB = 4'b1010. Read-back gives 0x11BB33DD.
- **Simultaneous AR+AW in IDLE:** the read is served first with AWREADY = 0. The write is accepted in the cycle the FSM returns to IDLE.
- **Backpressure and protocol error:**
  - RREADY low for 5 cycles → RDATA/RVALID held stable.
  - Early WLAST on beat 2 of LEN 3 → 4 beats are still written, BRESP = 2'b10.
- **Reset mid-burst:** rst = 1 during RD_DATA → next cycle all outputs at reset values. A fresh read after reset completes correctly.
